// File: rtl/brush_pixel_painter.sv
// Brush painter: sweeps a (2R+1)^2 brush around the latched mouse centre into VRAM, one write per grant.
// Define BRUSH_CIRCLE_EN to skip points outside radius R and get a round brush.
module brush_pixel_painter #(
   parameter int COLUMNS      = 640,
   parameter int ROWS         = 400,
   parameter int ADDR_WIDTH   = $clog2(COLUMNS*ROWS),
   parameter int DATA_WIDTH   = 2,
   parameter int BRUSH_RADIUS = 2,
   parameter int NUM_TYPES    = 4
) (
   input  logic                        clk_i,
   input  logic                        reset_i,
   input  logic                        draw_en_i,
   input  logic                        cycle_type_i,
   input  logic [$clog2(COLUMNS)-1:0]  mouse_x_position_i,
   input  logic [$clog2(ROWS)-1:0]     mouse_y_position_i,
   input  logic                        wr_grant_i,
   output logic                        wr_en_o,
   output logic [ADDR_WIDTH-1:0]       wr_address_o,
   output logic [DATA_WIDTH-1:0]       wr_data_o,
   output logic                        busy_o,
   output logic                        done_o,
   output logic [DATA_WIDTH-1:0]       pixel_type_o
);

   localparam int XW = $clog2(COLUMNS);
   localparam int YW = $clog2(ROWS);
   localparam int OW = $clog2(BRUSH_RADIUS + 1) + 1;

   localparam logic signed [OW-1:0]   R_POS    = OW'(BRUSH_RADIUS);
   localparam logic signed [OW-1:0]   R_NEG    = -R_POS;
   localparam logic signed [OW-1:0]   OFS_ONE  = OW'(1);
   localparam logic signed [XW:0]     COLS_S   = (XW+1)'(COLUMNS);
   localparam logic signed [YW:0]     ROWS_S   = (YW+1)'(ROWS);
   localparam logic [DATA_WIDTH-1:0]  TYPE_MAX = DATA_WIDTH'(NUM_TYPES - 1);
   localparam logic [DATA_WIDTH-1:0]  TYPE_ONE = DATA_WIDTH'(1);

   typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_e;

   state_e                  state_q, state_d;
   logic [XW-1:0]           cx_q, cx_d;
   logic [YW-1:0]           cy_q, cy_d;
   logic signed [OW-1:0]    dx_q, dx_d;
   logic signed [OW-1:0]    dy_q, dy_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;
   logic [DATA_WIDTH-1:0]   type_q, type_d;

   // Point under the cursor, one guard bit so negative offsets near the edge stay negative.
   logic signed [XW:0]      px;
   logic signed [YW:0]      py;
   logic                    in_bounds;
   logic                    outside_circle;
   logic                    write_point;
   logic                    advance;
   logic [ADDR_WIDTH-1:0]   addr;

   assign px = $signed({1'b0, cx_q}) + (XW+1)'(dx_q);
   assign py = $signed({1'b0, cy_q}) + (YW+1)'(dy_q);
   assign in_bounds = !px[XW] && (px < COLS_S) && !py[YW] && (py < ROWS_S);
   assign addr = ADDR_WIDTH'(py[YW-1:0]) * ADDR_WIDTH'(COLUMNS) + ADDR_WIDTH'(px[XW-1:0]);

`ifdef BRUSH_CIRCLE_EN
   assign outside_circle = (int'(dx_q) * int'(dx_q) + int'(dy_q) * int'(dy_q))
                           > BRUSH_RADIUS * BRUSH_RADIUS;
`else
   assign outside_circle = 1'b0;
`endif

   assign write_point = (state_q == SWEEP) && in_bounds && !outside_circle;
   assign advance     = (state_q == SWEEP) && (!write_point || wr_grant_i);

   assign wr_en_o      = write_point;
   assign wr_address_o = write_point ? addr : '0;
   assign wr_data_o    = write_point ? data_q : '0;
   assign busy_o       = (state_q != IDLE);
   assign done_o       = (state_q == DONE);
   assign pixel_type_o = type_q;

   always_comb begin
      type_d = type_q;
      if (cycle_type_i) begin
         type_d = (type_q == TYPE_MAX) ? '0 : type_q + TYPE_ONE;
      end
   end

   // NOTE: every next-state signal takes its hold value first, so no path through the case can infer a latch.
   always_comb begin
      state_d = state_q;
      cx_d    = cx_q;
      cy_d    = cy_q;
      dx_d    = dx_q;
      dy_d    = dy_q;
      data_d  = data_q;
      case (state_q)
         IDLE: begin
            if (draw_en_i) begin
               cx_d    = mouse_x_position_i;
               cy_d    = mouse_y_position_i;
               data_d  = type_q;
               dx_d    = R_NEG;
               dy_d    = R_NEG;
               state_d = SWEEP;
            end
         end
         SWEEP: begin
            if (advance) begin
               if (dx_q == R_POS) begin
                  dx_d = R_NEG;
                  if (dy_q == R_POS) begin
                     state_d = DONE;
                  end else begin
                     dy_d = dy_q + OFS_ONE;
                  end
               end else begin
                  dx_d = dx_q + OFS_ONE;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: non-blocking assignments here so every register samples the pre-edge values of the others.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         cx_q    <= '0;
         cy_q    <= '0;
         dx_q    <= '0;
         dy_q    <= '0;
         data_q  <= '0;
         type_q  <= TYPE_ONE;
      end else begin
         state_q <= state_d;
         cx_q    <= cx_d;
         cy_q    <= cy_d;
         dx_q    <= dx_d;
         dy_q    <= dy_d;
         data_q  <= data_d;
         type_q  <= type_d;
      end
   end

endmodule

// File: tb/tb_brush_pixel_painter.sv
// Scoreboard bench for brush_pixel_painter: a brush model queues expected writes, a monitor pops them.
module tb_brush_pixel_painter;

   localparam int COLUMNS = 640;
   localparam int ROWS    = 400;
   localparam int R       = 2;
   localparam int NT      = 4;
   localparam int AW      = $clog2(COLUMNS*ROWS);
   localparam int DW      = 2;
   localparam int XW      = $clog2(COLUMNS);
   localparam int YW      = $clog2(ROWS);

   typedef struct {
      int addr;
      int data;
   } exp_t;

   logic           clk_i = 1'b0;
   logic           reset_i;
   logic           draw_en_i;
   logic           cycle_type_i;
   logic [XW-1:0]  mouse_x_position_i;
   logic [YW-1:0]  mouse_y_position_i;
   logic           wr_grant_i;
   logic           wr_en_o;
   logic [AW-1:0]  wr_address_o;
   logic [DW-1:0]  wr_data_o;
   logic           busy_o;
   logic           done_o;
   logic [DW-1:0]  pixel_type_o;

   exp_t exp_q[$];
   exp_t mon_e;
   int   total = 0;
   int   bad = 0;
   int   wr_cnt = 0;
   int   exp_type = 1;

   brush_pixel_painter #(
      .COLUMNS(COLUMNS), .ROWS(ROWS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
      .BRUSH_RADIUS(R), .NUM_TYPES(NT)
   ) dut (
      .clk_i(clk_i), .reset_i(reset_i), .draw_en_i(draw_en_i), .cycle_type_i(cycle_type_i),
      .mouse_x_position_i(mouse_x_position_i), .mouse_y_position_i(mouse_y_position_i),
      .wr_grant_i(wr_grant_i), .wr_en_o(wr_en_o), .wr_address_o(wr_address_o),
      .wr_data_o(wr_data_o), .busy_o(busy_o), .done_o(done_o), .pixel_type_o(pixel_type_o)
   );

   always #5 clk_i = ~clk_i;

   // Monitor: every accepted write is checked against the head of the scoreboard.
   always @(negedge clk_i) begin
      if (reset_i === 1'b0 && wr_en_o === 1'b1 && wr_grant_i === 1'b1) begin
         wr_cnt++;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL write_unexpected: got addr=%0d data=%0d, expected no write", wr_address_o, wr_data_o);
         end else begin
            mon_e = exp_q.pop_front();
            if (wr_address_o !== AW'(mon_e.addr) || wr_data_o !== DW'(mon_e.data)) begin
               bad++;
               $display("FAIL write_%0d: got addr=%0d data=%0d, expected addr=%0d data=%0d",
                        wr_cnt, wr_address_o, wr_data_o, mon_e.addr, mon_e.data);
            end
         end
      end
   end

   task automatic push_brush(input int cx, input int cy, input int data);
      for (int dy = -R; dy <= R; dy++) begin
         for (int dx = -R; dx <= R; dx++) begin
            int x;
            int y;
            x = cx + dx;
            y = cy + dy;
            if (x >= 0 && x < COLUMNS && y >= 0 && y < ROWS
`ifdef BRUSH_CIRCLE_EN
                && (dx*dx + dy*dy) <= R*R
`endif
               ) begin
               exp_q.push_back('{addr: y*COLUMNS + x, data: data});
            end
         end
      end
   endtask

   task automatic apply_reset();
      reset_i      = 1'b1;
      draw_en_i    = 1'b0;
      cycle_type_i = 1'b0;
      wr_grant_i   = 1'b1;
      repeat (2) @(posedge clk_i);
      #1 reset_i = 1'b0;
      exp_type = 1;
   endtask

   // Returns one ns after the edge that samples draw_en_i high.
   task automatic start_stroke(input int x, input int y, input bit hold);
      @(posedge clk_i);
      #1;
      mouse_x_position_i = XW'(x);
      mouse_y_position_i = YW'(y);
      draw_en_i = 1'b1;
      @(posedge clk_i);
      #1;
      if (!hold) draw_en_i = 1'b0;
   endtask

   task automatic wait_done(output int cyc, output bit seen, output bit busy_ok);
      cyc = 0;
      seen = 1'b0;
      busy_ok = 1'b1;
      while (!seen && cyc < 300) begin
         @(negedge clk_i);
         cyc++;
         if (busy_o !== 1'b1) busy_ok = 1'b0;
         if (done_o === 1'b1) seen = 1'b1;
      end
   endtask

   task automatic pulse_type();
      @(posedge clk_i);
      #1 cycle_type_i = 1'b1;
      @(posedge clk_i);
      #1 cycle_type_i = 1'b0;
      exp_type = (exp_type + 1) % NT;
   endtask

   task automatic test_reset();
      reset_i = 1'b1;
      draw_en_i = 1'b0;
      cycle_type_i = 1'b0;
      wr_grant_i = 1'b1;
      mouse_x_position_i = '0;
      mouse_y_position_i = '0;
      @(negedge clk_i);
      total++;
      if (wr_en_o !== 1'b0 || wr_address_o !== '0 || wr_data_o !== '0) begin
         bad++;
         $display("FAIL reset_bus: got en=%b addr=%0d data=%0d, expected 0 0 0", wr_en_o, wr_address_o, wr_data_o);
      end
      total++;
      if (busy_o !== 1'b0 || done_o !== 1'b0 || pixel_type_o !== DW'(1)) begin
         bad++;
         $display("FAIL reset_status: got busy=%b done=%b type=%0d, expected 0 0 1", busy_o, done_o, pixel_type_o);
      end
      @(posedge clk_i);
      #1 reset_i = 1'b0;
      exp_type = 1;
      @(negedge clk_i);
      total++;
      if (busy_o !== 1'b0 || wr_en_o !== 1'b0) begin
         bad++;
         $display("FAIL reset_release: got busy=%b en=%b, expected 0 0", busy_o, wr_en_o);
      end
   endtask

   task automatic test_single_stroke();
      int cyc;
      bit seen;
      bit busy_ok;
      int n;
      push_brush(100, 50, exp_type);
      n = exp_q.size();
      wr_cnt = 0;
      start_stroke(100, 50, 1'b0);
      wait_done(cyc, seen, busy_ok);
      total++;
      if (!seen || cyc != 26) begin
         bad++;
         $display("FAIL stroke_done_cycle: got seen=%b cycle=%0d, expected seen=1 cycle=26", seen, cyc);
      end
      total++;
      if (wr_cnt != n || !busy_ok) begin
         bad++;
         $display("FAIL stroke_writes: got writes=%0d busy_ok=%b, expected writes=%0d busy_ok=1", wr_cnt, busy_ok, n);
      end
      @(negedge clk_i);
      total++;
      if (done_o !== 1'b0 || busy_o !== 1'b0) begin
         bad++;
         $display("FAIL stroke_after_done: got done=%b busy=%b, expected 0 0", done_o, busy_o);
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL stroke_leftover: got %0d pending writes, expected 0", exp_q.size());
      end
   endtask

   task automatic test_corner_clip();
      int cyc;
      bit seen;
      bit busy_ok;
      int n;
      push_brush(0, 0, exp_type);
      n = exp_q.size();
      wr_cnt = 0;
      start_stroke(0, 0, 1'b0);
      wait_done(cyc, seen, busy_ok);
      total++;
      if (!seen || cyc != 26 || wr_cnt != n) begin
         bad++;
         $display("FAIL corner_clip: got seen=%b cycle=%0d writes=%0d, expected seen=1 cycle=26 writes=%0d",
                  seen, cyc, wr_cnt, n);
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL corner_leftover: got %0d pending writes, expected 0", exp_q.size());
      end
   endtask

   task automatic test_grant_stall();
      int cyc;
      bit seen;
      bit busy_ok;
      int n;
      int stall_addr;
      push_brush(100, 50, exp_type);
      n = exp_q.size();
      stall_addr = exp_q[2].addr;
      wr_cnt = 0;
      start_stroke(100, 50, 1'b0);
      @(posedge clk_i);
      @(posedge clk_i);
      #1 wr_grant_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_i);
         total++;
         if (wr_en_o !== 1'b1 || wr_address_o !== AW'(stall_addr)) begin
            bad++;
            $display("FAIL stall_hold_%0d: got en=%b addr=%0d, expected en=1 addr=%0d", i, wr_en_o, wr_address_o, stall_addr);
         end
      end
      @(posedge clk_i);
      #1 wr_grant_i = 1'b1;
      wait_done(cyc, seen, busy_ok);
      total++;
      if (!seen || wr_cnt != n || exp_q.size() != 0) begin
         bad++;
         $display("FAIL stall_totals: got seen=%b writes=%0d pending=%0d, expected seen=1 writes=%0d pending=0",
                  seen, wr_cnt, exp_q.size(), n);
      end
   endtask

   task automatic test_type_cycle();
      int cyc;
      bit seen;
      bit busy_ok;
      int n;
      apply_reset();
      @(negedge clk_i);
      total++;
      if (pixel_type_o !== DW'(exp_type)) begin
         bad++;
         $display("FAIL type_initial: got %0d, expected %0d", pixel_type_o, exp_type);
      end
      for (int i = 0; i < 2; i++) begin
         pulse_type();
         @(negedge clk_i);
         total++;
         if (pixel_type_o !== DW'(exp_type)) begin
            bad++;
            $display("FAIL type_step_%0d: got %0d, expected %0d", i, pixel_type_o, exp_type);
         end
      end
      push_brush(300, 200, exp_type);
      n = exp_q.size();
      wr_cnt = 0;
      @(posedge clk_i);
      #1;
      mouse_x_position_i = XW'(300);
      mouse_y_position_i = YW'(200);
      draw_en_i = 1'b1;
      cycle_type_i = 1'b1;
      @(posedge clk_i);
      #1;
      draw_en_i = 1'b0;
      cycle_type_i = 1'b0;
      exp_type = (exp_type + 1) % NT;
      @(negedge clk_i);
      total++;
      if (pixel_type_o !== DW'(exp_type) || wr_data_o !== DW'(3)) begin
         bad++;
         $display("FAIL type_wrap_stroke: got type=%0d data=%0d, expected type=%0d data=3", pixel_type_o, wr_data_o, exp_type);
      end
      wait_done(cyc, seen, busy_ok);
      total++;
      if (!seen || wr_cnt != n || exp_q.size() != 0) begin
         bad++;
         $display("FAIL type_stroke_totals: got seen=%b writes=%0d pending=%0d, expected seen=1 writes=%0d pending=0",
                  seen, wr_cnt, exp_q.size(), n);
      end
   endtask

   task automatic test_reset_mid_stroke();
      bit stray;
      pulse_type();
      pulse_type();
      push_brush(100, 50, exp_type);
      wr_cnt = 0;
      start_stroke(100, 50, 1'b1);
      repeat (9) @(posedge clk_i);
      #1;
      total++;
      if (wr_en_o !== 1'b1 || wr_data_o !== DW'(exp_type)) begin
         bad++;
         $display("FAIL abort_tenth_request: got en=%b data=%0d, expected en=1 data=%0d", wr_en_o, wr_data_o, exp_type);
      end
      reset_i = 1'b1;
      #1;
      exp_type = 1;
      total++;
      if (wr_en_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 || pixel_type_o !== DW'(exp_type)) begin
         bad++;
         $display("FAIL abort_immediate: got en=%b busy=%b done=%b type=%0d, expected 0 0 0 %0d",
                  wr_en_o, busy_o, done_o, pixel_type_o, exp_type);
      end
      exp_q.delete();
      draw_en_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1 reset_i = 1'b0;
      stray = 1'b0;
      repeat (40) begin
         @(negedge clk_i);
         if (wr_en_o !== 1'b0 || busy_o !== 1'b0) stray = 1'b1;
      end
      total++;
      if (stray || wr_cnt != 9) begin
         bad++;
         $display("FAIL abort_no_more_writes: got stray=%b writes=%0d, expected stray=0 writes=9", stray, wr_cnt);
      end
   endtask

   task automatic test_back_to_back();
      int cyc;
      bit seen;
      bit busy_ok;
      int n;
      push_brush(200, 100, exp_type);
      push_brush(210, 110, exp_type);
      n = exp_q.size();
      wr_cnt = 0;
      start_stroke(200, 100, 1'b1);
      mouse_x_position_i = XW'(210);
      mouse_y_position_i = YW'(110);
      repeat (27) @(posedge clk_i);
      #1 draw_en_i = 1'b0;
      wait_done(cyc, seen, busy_ok);
      total++;
      if (!seen || wr_cnt != n || exp_q.size() != 0) begin
         bad++;
         $display("FAIL back_to_back: got seen=%b writes=%0d pending=%0d, expected seen=1 writes=%0d pending=0",
                  seen, wr_cnt, exp_q.size(), n);
      end
      @(negedge clk_i);
      total++;
      if (busy_o !== 1'b0) begin
         bad++;
         $display("FAIL back_to_back_idle: got busy=%b, expected 0", busy_o);
      end
   endtask

   initial begin
      test_reset();
      test_single_stroke();
      test_corner_clip();
      test_grant_stall();
      test_type_cycle();
      test_reset_mid_stroke();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
